hamming84_stream_encoder: RTL and testbench



---
 rtl/hamming84_stream_encoder.sv | 126 ++++++++++++
 tb/tb_hamming84_stream_encoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming84_stream_encoder.sv
// Streaming Hamming(8,4) SECDED encoder: byte in, two codewords out, low nibble first.
// Optional error injection is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming84_stream_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] cw_count
`ifdef HAMMING_ERR_INJECT_EN
  ,
  input  logic [7:0]       inj_mask
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {^c, c};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       hi_q, hi_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lo_cw, hi_cw;
  logic             accept, take;

`ifdef HAMMING_ERR_INJECT_EN
  logic [7:0] mask_q, mask_d;
`endif

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = LO;
      LO:   if (out_ready) state_d = HI;
      HI:   if (out_ready) state_d = accept ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == HI) & out_ready);
    out_valid = (state_q != IDLE);
    out_last  = (state_q == HI);
  end

  // Mask is applied as each codeword is loaded, never on the output path.
  always_comb begin
    lo_cw = enc(in_data[3:0]);
    hi_cw = enc(hi_q);
`ifdef HAMMING_ERR_INJECT_EN
    lo_cw = lo_cw ^ inj_mask;
    hi_cw = hi_cw ^ mask_q;
`endif
  end

  always_comb begin
    data_d = data_q;
    hi_d   = hi_q;
    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, take};
`ifdef HAMMING_ERR_INJECT_EN
    mask_d = mask_q;
    if (accept) mask_d = inj_mask;
`endif
    if (accept) hi_d = in_data[7:4];
    unique case (state_q)
      IDLE: if (accept) data_d = lo_cw;
      LO:   if (out_ready) data_d = hi_cw;
      HI:   if (out_ready) data_d = accept ? lo_cw : 8'h00;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= 8'h00;
      hi_q   <= 4'h0;
      cnt_q  <= '0;
`ifdef HAMMING_ERR_INJECT_EN
      mask_q <= 8'h00;
`endif
    end else begin
      data_q <= data_d;
      hi_q   <= hi_d;
      cnt_q  <= cnt_d;
`ifdef HAMMING_ERR_INJECT_EN
      mask_q <= mask_d;
`endif
    end
  end

  assign out_data = data_q;
  assign cw_count = cnt_q;

endmodule

// File: tb/tb_hamming84_stream_encoder.sv
// Self-checking bench for hamming84_stream_encoder (CNT_W=4).
// Covers the HAMMING_ERR_INJECT_EN build when that macro is defined.
module tb_hamming84_stream_encoder;

  localparam int CNT_W = 4;

  logic             clk = 0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] cw_count;
  logic [7:0]       inj_mask;

  hamming84_stream_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .cw_count  (cw_count)
`ifdef HAMMING_ERR_INJECT_EN
    ,
    .inj_mask  (inj_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference code: data at non-power-of-two positions, parity p covers
  // every position whose index has bit p set, plus overall parity on bit 7.
  function automatic logic [7:0] model_enc(input logic [3:0] d);
    logic [7:0] c;
    logic x;
    int k;
    int p;
    c = 8'h00;
    k = 0;
    for (int pos = 1; pos <= 7; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    for (int b = 0; b < 3; b++) begin
      p = 1 << b;
      x = 1'b0;
      for (int q = 1; q <= 7; q++)
        if ((q & p) != 0 && q != p) x = x ^ c[q-1];
      c[p-1] = x;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  function automatic void model_dec(input logic [7:0] c,
                                    output logic [3:0] d,
                                    output logic sec,
                                    output logic ded);
    int syn;
    logic par;
    logic [7:0] f;
    syn = 0;
    f = c;
    for (int q = 1; q <= 7; q++)
      if (c[q-1]) syn = syn ^ q;
    par = ^c;
    sec = 1'b0;
    ded = 1'b0;
    if (syn != 0 && !par) begin
      ded = 1'b1;
    end else if (par) begin
      sec = 1'b1;
      if (syn != 0) f[syn-1] = ~f[syn-1];
      else f[7] = ~f[7];
    end
    d = {f[6], f[5], f[4], f[2]};
  endfunction

  task automatic send(input logic [7:0] b, output logic [7:0] lo,
                      output logic [7:0] hi);
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lo_valid", out_valid, 1);
    chk("lo_last", out_last, 0);
    lo = out_data;
    @(negedge clk);
    #1 chk("hi_valid", out_valid, 1);
    chk("hi_last", out_last, 1);
    hi = out_data;
    @(negedge clk);
    #1 chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 8'h00);
    exp_cnt = exp_cnt + 2;
    chk("cw_count", cw_count, exp_cnt);
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;

  typedef struct {
    logic [7:0] cw;
    logic       last;
  } cw_t;

  vec_t vecs[5];
  logic [7:0] bp_dat[6];
  logic       bp_last[6];
  logic [7:0] bp_in[6];
  logic       bp_vld[6];
  cw_t        q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo, hi;
    logic [3:0] d;
    logic sec, ded;
    logic hold, mready, acc;

    vecs[0] = '{8'hA5, 8'h2D, 8'hD2};
    vecs[1] = '{8'h00, 8'h00, 8'h00};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[3] = '{8'h12, 8'h99, 8'h87};
    vecs[4] = '{8'h34, 8'hAA, 8'h1E};

    rst = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inj_mask = 8'h00;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    #1 chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 0);
    chk("rst_cnt", cw_count, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      send(vecs[i].b, lo, hi);
      chk("vec_lo", lo, vecs[i].lo);
      chk("vec_hi", hi, vecs[i].hi);
    end

    // Backpressure on 0xA5, with 0x12 waiting, then 0x34 streamed.
    @(negedge clk);
    in_data = 8'hA5;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_data = 8'h12;
    repeat (5) begin
      #1 chk("bp_hold_data", out_data, 8'h2D);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      @(negedge clk);
    end
    bp_dat  = '{8'h2D, 8'hD2, 8'h99, 8'h87, 8'hAA, 8'h1E};
    bp_last = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bp_in   = '{8'h12, 8'h12, 8'h34, 8'h34, 8'h00, 8'h00};
    bp_vld  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      in_data = bp_in[k];
      in_valid = bp_vld[k];
      #1 chk("b2b_data", out_data, bp_dat[k]);
      chk("b2b_last", out_last, bp_last[k]);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_ready", in_ready, bp_last[k]);
    end
    @(negedge clk);
    #1 chk("b2b_idle", out_valid, 0);
    exp_cnt = exp_cnt + 6;
    chk("b2b_cnt", cw_count, exp_cnt);

    // Reset while the high-nibble codeword is presented.
    @(negedge clk);
    in_data = 8'h5A;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("mid_in_hi", out_last, 1);
    #1 rst = 1'b1;
    #1 chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 8'h00);
    chk("mid_last", out_last, 0);
    chk("mid_cnt", cw_count, 0);
    chk("mid_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_cnt = '0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("mid_no_cw", out_valid, 0);
    end

    // Counter wrap: 16 codewords, then one more.
    for (int k = 0; k < 8; k++) begin
      in_data = 8'($urandom);
      send(in_data, lo, hi);
      chk("wrap_lo", lo, model_enc(in_data[3:0]));
      chk("wrap_hi", hi, model_enc(in_data[7:4]));
    end
    chk("wrap_zero", cw_count, 0);
    @(negedge clk);
    in_data = 8'h3C;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("wrap_17", cw_count, 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt = 4'd2;
    #1 chk("wrap_18", cw_count, exp_cnt);

    // Round-trip every nibble through the decoder model.
    for (int n = 0; n < 16; n++) begin
      send({4'(n), 4'(n)}, lo, hi);
      chk("rt_enc", lo, model_enc(4'(n)));
      model_dec(lo, d, sec, ded);
      chk("rt_data", d, n);
      chk("rt_sec", sec, 0);
      chk("rt_ded", ded, 0);
      model_dec(hi, d, sec, ded);
      chk("rt_data_hi", d, n);
      chk("rt_flags_hi", {sec, ded}, 0);
    end

`ifdef HAMMING_ERR_INJECT_EN
    inj_mask = 8'h01;
    send(8'h00, lo, hi);
    inj_mask = 8'h00;
    chk("inj_lo", lo, 8'h01);
    chk("inj_hi", hi, 8'h01);
    model_dec(lo, d, sec, ded);
    chk("inj_sec", sec, 1);
    chk("inj_data", d, 0);
    inj_mask = 8'h03;
    send(8'h00, lo, hi);
    inj_mask = 8'h00;
    model_dec(hi, d, sec, ded);
    chk("inj_ded", ded, 1);
    send(8'h00, lo, hi);
    chk("inj_clean", {lo, hi}, 16'h0000);
`endif

    // Random traffic against a queue model.
    hold = 1'b0;
    in_valid = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      mready = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("rnd_valid", out_valid, q.size() != 0);
      chk("rnd_ready", in_ready, mready);
      chk("rnd_cnt", cw_count, exp_cnt);
      if (q.size() != 0) begin
        chk("rnd_data", out_data, q[0].cw);
        chk("rnd_last", out_last, q[0].last);
      end
      acc = in_valid && mready;
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        exp_cnt = exp_cnt + 1;
      end
      if (acc) begin
        q.push_back('{model_enc(in_data[3:0]), 1'b0});
        q.push_back('{model_enc(in_data[7:4]), 1'b1});
      end
      hold = in_valid && !acc;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
